// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state codes, default frame geometry and a width helper.
package uart_pkg;

    // Receive/transmit FSM state codes.
    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] START = 2'b01;
    localparam logic [1:0] DATA  = 2'b10;
    localparam logic [1:0] STOP  = 2'b11;

    // Default frame geometry: 8 data bits, 16x oversampling, one stop bit.
    localparam int unsigned UART_NB_DATA    = 8;
    localparam int unsigned UART_OVERSAMPLE = 16;
    localparam int unsigned UART_SB_TICK    = 16;

    // Counter width able to hold 0..v-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Byte-side and line-side signals of the UART receive controller.
interface uart_rx_ctrl_if
    import uart_pkg::*;
#(
    parameter int unsigned NB_DATA = UART_NB_DATA
);

    logic               i_tick;
    logic               i_rx;
    logic [NB_DATA-1:0] o_data;
    logic               o_rx_done;
    logic               o_frame_err;

    // Upstream side: supplies the oversampling tick and the serial line.
    modport master (
        output i_tick,
        output i_rx,
        input  o_data,
        input  o_rx_done,
        input  o_frame_err
    );

    // Receive controller side.
    modport slave (
        input  i_tick,
        input  i_rx,
        output o_data,
        output o_rx_done,
        output o_frame_err
    );

endinterface

// File: rtl/rx_sync.sv
// Two-flop synchroniser for asynchronous inputs; resets to all ones (idle-high lines).
module rx_sync #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two register stages to let a metastable first stage settle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= i_d;
            sync_q <= meta_q;
        end
    end

    assign o_q = sync_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART 8N1 receive controller driven by a 16x oversampling tick.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned NB_DATA    = UART_NB_DATA,
    parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE,
    parameter int unsigned SB_TICK    = UART_SB_TICK
) (
    input  logic           i_clk,
    input  logic           i_reset,
    uart_rx_ctrl_if.slave  bus
);

    localparam int unsigned S_MAX = (OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK;
    localparam int unsigned S_W   = cnt_width(S_MAX);
    localparam int unsigned N_W   = cnt_width(NB_DATA);

    localparam logic [S_W-1:0] S_MID      = S_W'(OVERSAMPLE / 2 - 1);
    localparam logic [S_W-1:0] S_BIT_END  = S_W'(OVERSAMPLE - 1);
    localparam logic [S_W-1:0] S_STOP_END = S_W'(SB_TICK - 1);
    localparam logic [N_W-1:0] N_LAST     = N_W'(NB_DATA - 1);

    logic               rx_s;
    logic [1:0]         state_q, state_d;
    logic [S_W-1:0]     s_q, s_d;
    logic [N_W-1:0]     n_q, n_d;
    logic [NB_DATA-1:0] sh_q, sh_d;
    logic               stop_done;

    logic [NB_DATA-1:0] data_q;
    logic               done_q;
    logic               ferr_q;

    rx_sync #(
        .WIDTH (1)
    ) u_rx_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_d     (bus.i_rx),
        .o_q     (rx_s)
    );

    // Next-state logic; everything except start detection waits for a tick.
    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        n_d       = n_q;
        sh_d      = sh_q;
        stop_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                if (bus.i_tick) begin
                    if (s_q == S_MID) begin
                        if (!rx_s) begin
                            state_d = DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (bus.i_tick) begin
                    if (s_q == S_BIT_END) begin
                        s_d  = '0;
                        sh_d = {rx_s, sh_q[NB_DATA-1:1]};
                        if (n_q == N_LAST) begin
                            state_d = STOP;
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (bus.i_tick) begin
                    if (s_q == S_STOP_END) begin
                        state_d   = IDLE;
                        stop_done = 1'b1;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state, tick/bit counters and shift register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            sh_q    <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            sh_q    <= sh_d;
        end
    end

    // Output registers: byte and frame error held between strobes, done is one cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            data_q <= '0;
            done_q <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            done_q <= stop_done;
            if (stop_done) begin
                data_q <= sh_q;
                ferr_q <= ~rx_s;
            end
        end
    end

    assign bus.o_data      = data_q;
    assign bus.o_rx_done   = done_q;
    assign bus.o_frame_err = ferr_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: serial frames in, expected {frame_err, byte} queue out.
module tb_uart_rx_ctrl;

    localparam int BIT_CLKS = 64;

    logic i_clk = 1'b0;
    logic i_reset;

    uart_rx_ctrl_if #(.NB_DATA(8)) bus ();

    uart_rx_ctrl #(
        .NB_DATA    (8),
        .OVERSAMPLE (16),
        .SB_TICK    (16)
    ) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus)
    );

    always #5 i_clk = ~i_clk;

    int         n_checks   = 0;
    int         n_fail     = 0;
    int         width_err  = 0;
    bit         tick_en    = 1'b1;
    int         tcnt       = 0;
    logic [8:0] obs_q[$];
    logic [8:0] exp_q[$];

    // Oversampling tick: one pulse every 4 clocks while enabled.
    initial begin
        bus.i_tick = 1'b0;
        forever begin
            @(negedge i_clk);
            tcnt++;
            bus.i_tick = tick_en && (tcnt % 4 == 0);
        end
    end

    // Strobe monitor: records {frame_err, data} per strobe and flags strobes wider than one cycle.
    initial begin
        bit prev;
        prev = 1'b0;
        forever begin
            @(negedge i_clk);
            if (bus.o_rx_done === 1'b1) begin
                if (prev) width_err++;
                else obs_q.push_back({bus.o_frame_err, bus.o_data});
            end
            prev = (bus.o_rx_done === 1'b1);
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clks(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic send_bit(input logic b, input int n);
        bus.i_rx = b;
        clks(n);
    endtask

    // Reference model: a frame with byte b and stop level stop_ok must yield {~stop_ok, b}.
    // A bad stop bit is held low just past its sampling point, then the line returns high.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int stall_bit);
        send_bit(1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            if (i == stall_bit) begin
                bus.i_rx = b[i];
                clks(32);
                tick_en = 1'b0;
                clks(200);
                tick_en = 1'b1;
                clks(32);
            end else begin
                send_bit(b[i], BIT_CLKS);
            end
        end
        if (stop_ok) send_bit(1'b1, BIT_CLKS);
        else begin
            send_bit(1'b0, 48);
            send_bit(1'b1, 16);
        end
        exp_q.push_back({~stop_ok, b});
    endtask

    task automatic test_reset();
        i_reset  = 1'b1;
        bus.i_rx = 1'b1;
        clks(4);
        i_reset = 1'b0;
        clks(2);
        n_checks++;
        if (bus.o_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %02h expected 00", bus.o_data); end
        n_checks++;
        if (bus.o_rx_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.o_rx_done); end
        n_checks++;
        if (bus.o_frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b expected 0", bus.o_frame_err); end
    endtask

    task automatic test_basic();
        logic [8:0] got, want;
        send_frame(8'hA5, 1'b1, -1);
        clks(BIT_CLKS);
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL basic_count: got %0d strobes expected %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q.pop_front(); want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin n_fail++; $display("FAIL basic_frame: got ferr=%b data=%02h expected ferr=%b data=%02h", got[8], got[7:0], want[8], want[7:0]); end
        end
        obs_q.delete(); exp_q.delete();
        n_checks++;
        if (bus.o_data !== 8'hA5) begin n_fail++; $display("FAIL basic_hold: got %02h expected a5", bus.o_data); end
        n_checks++;
        if (width_err !== 0) begin n_fail++; $display("FAIL basic_width: got %0d wide strobes expected 0", width_err); end
    endtask

    task automatic test_glitch();
        logic [8:0] got, want;
        send_bit(1'b0, 20);
        send_bit(1'b1, 200);
        n_checks++;
        if (obs_q.size() !== 0) begin n_fail++; $display("FAIL glitch_no_strobe: got %0d strobes expected 0", obs_q.size()); end
        send_frame(8'h3C, 1'b1, -1);
        clks(BIT_CLKS);
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL glitch_count: got %0d strobes expected %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q.pop_front(); want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin n_fail++; $display("FAIL glitch_frame: got ferr=%b data=%02h expected ferr=%b data=%02h", got[8], got[7:0], want[8], want[7:0]); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_frame_err();
        logic [8:0] got, want;
        send_frame(8'h3C, 1'b0, -1);
        clks(BIT_CLKS);
        n_checks++;
        if (bus.o_frame_err !== 1'b1) begin n_fail++; $display("FAIL ferr_set: got %b expected 1", bus.o_frame_err); end
        n_checks++;
        if (bus.o_data !== 8'h3C) begin n_fail++; $display("FAIL ferr_data: got %02h expected 3c", bus.o_data); end
        send_frame(8'h81, 1'b1, -1);
        clks(BIT_CLKS);
        n_checks++;
        if (bus.o_frame_err !== 1'b0) begin n_fail++; $display("FAIL ferr_clear: got %b expected 0", bus.o_frame_err); end
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL ferr_count: got %0d strobes expected %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q.pop_front(); want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin n_fail++; $display("FAIL ferr_frame: got ferr=%b data=%02h expected ferr=%b data=%02h", got[8], got[7:0], want[8], want[7:0]); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [8:0] got, want;
        send_frame(8'h00, 1'b1, -1);
        send_frame(8'hFF, 1'b1, -1);
        clks(BIT_CLKS);
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL b2b_count: got %0d strobes expected %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q.pop_front(); want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin n_fail++; $display("FAIL b2b_frame: got ferr=%b data=%02h expected ferr=%b data=%02h", got[8], got[7:0], want[8], want[7:0]); end
        end
        obs_q.delete(); exp_q.delete();
        n_checks++;
        if (bus.o_data !== 8'hFF) begin n_fail++; $display("FAIL b2b_last: got %02h expected ff", bus.o_data); end
    endtask

    // The transmitter abandons the 0x55 frame after the reset, so the line stays idle-high.
    task automatic test_reset_mid();
        logic [8:0] got, want;
        logic [7:0] b;
        b = 8'h55;
        send_bit(1'b0, BIT_CLKS);
        for (int i = 0; i < 4; i++) send_bit(b[i], BIT_CLKS);
        send_bit(b[4], 20);
        i_reset = 1'b1;
        clks(1);
        i_reset = 1'b0;
        send_bit(1'b1, 10 * BIT_CLKS);
        n_checks++;
        if (obs_q.size() !== 0) begin n_fail++; $display("FAIL rstmid_no_strobe: got %0d strobes expected 0", obs_q.size()); end
        n_checks++;
        if (bus.o_data !== 8'h00) begin n_fail++; $display("FAIL rstmid_data: got %02h expected 00", bus.o_data); end
        n_checks++;
        if (bus.o_frame_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_ferr: got %b expected 0", bus.o_frame_err); end
        send_frame(8'h55, 1'b1, -1);
        clks(BIT_CLKS);
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rstmid_count: got %0d strobes expected %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q.pop_front(); want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin n_fail++; $display("FAIL rstmid_frame: got ferr=%b data=%02h expected ferr=%b data=%02h", got[8], got[7:0], want[8], want[7:0]); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_tick_stall();
        logic [8:0] got, want;
        send_frame(8'hC3, 1'b1, 3);
        clks(BIT_CLKS);
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL stall_count: got %0d strobes expected %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q.pop_front(); want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin n_fail++; $display("FAIL stall_frame: got ferr=%b data=%02h expected ferr=%b data=%02h", got[8], got[7:0], want[8], want[7:0]); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    // Random bytes and stop levels; after a bad stop bit the line idles long enough
    // for the false start seen at the stop-bit sample point to be rejected.
    task automatic test_random();
        logic [8:0] got, want;
        logic [7:0] b;
        bit         ok;
        for (int i = 0; i < 10; i++) begin
            b  = 8'($urandom);
            ok = ($urandom_range(0, 3) != 0);
            send_frame(b, ok, -1);
            if (ok) clks($urandom_range(0, 40));
            else clks(40 + $urandom_range(0, 40));
        end
        clks(BIT_CLKS);
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rand_count: got %0d strobes expected %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q.pop_front(); want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin n_fail++; $display("FAIL rand_frame: got ferr=%b data=%02h expected ferr=%b data=%02h", got[8], got[7:0], want[8], want[7:0]); end
        end
        obs_q.delete(); exp_q.delete();
        n_checks++;
        if (width_err !== 0) begin n_fail++; $display("FAIL strobe_width: got %0d wide strobes expected 0", width_err); end
    endtask

    initial begin
        i_reset  = 1'b1;
        bus.i_rx = 1'b1;
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_reset_mid();
        test_tick_stall();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
